// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one latched byte per request into
// start / data (LSB first) / optional parity / stop bits, OVERSAMPLE ticks per bit.
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baudtick,
    input  logic                 txstart,
    input  logic [DATA_BITS-1:0] txdatain,
    output logic                 txout,
    output logic                 txbusy,
    output logic                 txdone
);

    localparam int             TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);
    localparam logic           ODD_SENSE = (PARITY_ODD != 0);
    localparam logic           PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [TW-1:0]          tick_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic                   stop_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_r;
    logic                   txout_r;
    logic                   txbusy_r;
    logic                   txdone_r;
    logic                   bit_end_s;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // A bit period closes on the baudtick that would bring the count to OVERSAMPLE
    assign bit_end_s = baudtick && (tick_cnt_r == TICK_LAST);

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
            txout_r    <= 1'b1;
            txbusy_r   <= 1'b0;
            txdone_r   <= 1'b0;
        end else begin
            txdone_r <= 1'b0;
            if (baudtick) begin
                if (bit_end_s) begin
                    tick_cnt_r <= {TW{1'b0}};
                end else begin
                    tick_cnt_r <= tick_cnt_r + TW'(1);
                end
            end
            case (state_r)
                ST_IDLE: begin
                    // a tick in the accept cycle must not count towards the start bit
                    tick_cnt_r <= {TW{1'b0}};
                    bit_cnt_r  <= 3'd0;
                    stop_cnt_r <= 1'b0;
                    if (txstart) begin
                        shift_r  <= txdatain;
                        par_r    <= calc_parity(txdatain, ODD_SENSE);
                        state_r  <= ST_START;
                        txout_r  <= 1'b0;
                        txbusy_r <= 1'b1;
                    end else begin
                        txout_r  <= 1'b1;
                        txbusy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 3'd0;
                        txout_r   <= shift_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        shift_r <= shift_r >> 1;
                        if (bit_cnt_r == BIT_LAST) begin
                            if (PAR_ON) begin
                                state_r <= ST_PARITY;
                                txout_r <= par_r;
                            end else begin
                                state_r    <= ST_STOP;
                                stop_cnt_r <= 1'b0;
                                txout_r    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            txout_r   <= shift_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r    <= ST_STOP;
                        stop_cnt_r <= 1'b0;
                        txout_r    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            txdone_r <= 1'b1;
                            // back-to-back request: next start bit follows with no idle gap
                            if (txstart) begin
                                shift_r  <= txdatain;
                                par_r    <= calc_parity(txdatain, ODD_SENSE);
                                state_r  <= ST_START;
                                txout_r  <= 1'b0;
                                txbusy_r <= 1'b1;
                            end else begin
                                state_r  <= ST_IDLE;
                                txout_r  <= 1'b1;
                                txbusy_r <= 1'b0;
                            end
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    txout_r  <= 1'b1;
                    txbusy_r <= 1'b0;
                end
            endcase
        end
    end

    assign txout  = txout_r;
    assign txbusy = txbusy_r;
    assign txdone = txdone_r;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: default framing, ignored requests, back-to-back,
// parity/stop variants and reset abort, with hand-computed line sequences.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baudtick = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic [7:0] data_b = 8'h00;
    logic       out_a, busy_a, done_a;
    logic       out_pe, busy_pe, done_pe;
    logic       out_po, busy_po, done_po;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    uart_tx_framer dut_a (
        .clk(clk), .reset(reset), .baudtick(baudtick), .txstart(start_a),
        .txdatain(data_a), .txout(out_a), .txbusy(busy_a), .txdone(done_a)
    );

    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
        .clk(clk), .reset(reset), .baudtick(baudtick), .txstart(start_b),
        .txdatain(data_b), .txout(out_pe), .txbusy(busy_pe), .txdone(done_pe)
    );

    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_po (
        .clk(clk), .reset(reset), .baudtick(baudtick), .txstart(start_b),
        .txdatain(data_b), .txout(out_po), .txbusy(busy_po), .txdone(done_po)
    );

    task automatic test_reset();
        reset = 1'b0; start_a = 1'b1; data_a = 8'hFF; start_b = 1'b1; data_b = 8'hFF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            baudtick = ~baudtick;
            checks++;
            if (out_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
                out_po !== 1'b1 || busy_pe !== 1'b0 || done_po !== 1'b0) begin
                errors++;
                $display("FAIL reset k=%0d out=%b busy=%b done=%b, required 1 0 0",
                         k, out_a, busy_a, done_a);
            end
        end
        start_a = 1'b0; start_b = 1'b0; baudtick = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame_a5();
        logic [9:0] line;
        line = {1'b1, 8'hA5, 1'b0};
        data_a = 8'hA5; start_a = 1'b1;
        for (int k = 0; k <= 161; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
            checks++;
            if (k < 160) begin
                if (out_a !== line[k/16] || busy_a !== 1'b1 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_a5 k=%0d out=%b busy=%b done=%b, required %b 1 0",
                             k, out_a, busy_a, done_a, line[k/16]);
                end
            end else if (k == 160) begin
                if (done_a !== 1'b1 || out_a !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_a5_done out=%b done=%b, required 1 1", out_a, done_a);
                end
            end else begin
                if (done_a !== 1'b0 || busy_a !== 1'b0 || out_a !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_a5_idle out=%b busy=%b done=%b, required 1 0 0",
                             out_a, busy_a, done_a);
                end
            end
        end
    endtask

    task automatic test_midframe_ignored();
        logic [9:0] line;
        int ndone;
        line = {1'b1, 8'hA5, 1'b0};
        ndone = 0;
        data_a = 8'hA5; start_a = 1'b1;
        for (int k = 0; k <= 170; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
            if (k == 80) begin start_a = 1'b1; data_a = 8'h3C; end
            if (k == 100) start_a = 1'b0;
            if (done_a === 1'b1) ndone++;
            if (k < 160) begin
                checks++;
                if (out_a !== line[k/16]) begin
                    errors++;
                    $display("FAIL midframe k=%0d out=%b, required %b", k, out_a, line[k/16]);
                end
            end
        end
        checks++;
        if (ndone != 1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midframe_done pulses=%0d busy=%b, required 1 0", ndone, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] line1, line2;
        line1 = {1'b1, 8'h01, 1'b0};
        line2 = {1'b1, 8'h80, 1'b0};
        data_a = 8'h01; start_a = 1'b1;
        for (int k = 0; k <= 321; k++) begin
            @(negedge clk);
            checks++;
            if (k < 160) begin
                if (out_a !== line1[k/16] || busy_a !== 1'b1 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_first k=%0d out=%b busy=%b done=%b, required %b 1 0",
                             k, out_a, busy_a, done_a, line1[k/16]);
                end
            end else if (k < 320) begin
                if (out_a !== line2[(k-160)/16] || busy_a !== 1'b1 || done_a !== (k == 160)) begin
                    errors++;
                    $display("FAIL b2b_second k=%0d out=%b busy=%b done=%b, required %b 1 %b",
                             k, out_a, busy_a, done_a, line2[(k-160)/16], (k == 160));
                end
            end else if (k == 320) begin
                if (done_a !== 1'b1 || out_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done2 out=%b done=%b, required 1 1", out_a, done_a);
                end
            end else begin
                if (busy_a !== 1'b0 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle busy=%b done=%b, required 0 0", busy_a, done_a);
                end
            end
            if (k == 0) data_a = 8'h80;
            if (k == 160) start_a = 1'b0;
        end
    endtask

    task automatic test_parity_stop();
        logic [10:0] line_pe;
        logic [11:0] line_po;
        line_pe = {1'b1, 1'b1, 8'h07, 1'b0};
        line_po = {2'b11, 1'b0, 8'h07, 1'b0};
        data_b = 8'h07; start_b = 1'b1;
        for (int k = 0; k <= 193; k++) begin
            @(negedge clk);
            if (k == 0) start_b = 1'b0;
            checks++;
            if (k < 176) begin
                if (out_pe !== line_pe[k/16] || busy_pe !== 1'b1 || done_pe !== 1'b0) begin
                    errors++;
                    $display("FAIL even_par k=%0d out=%b busy=%b done=%b, required %b 1 0",
                             k, out_pe, busy_pe, done_pe, line_pe[k/16]);
                end
            end else if (k == 176) begin
                if (done_pe !== 1'b1 || out_pe !== 1'b1) begin
                    errors++;
                    $display("FAIL even_par_done out=%b done=%b, required 1 1", out_pe, done_pe);
                end
            end else begin
                if (busy_pe !== 1'b0 || done_pe !== 1'b0 || out_pe !== 1'b1) begin
                    errors++;
                    $display("FAIL even_par_idle k=%0d out=%b busy=%b done=%b, required 1 0 0",
                             k, out_pe, busy_pe, done_pe);
                end
            end
            checks++;
            if (k < 192) begin
                if (out_po !== line_po[k/16] || busy_po !== 1'b1 || done_po !== 1'b0) begin
                    errors++;
                    $display("FAIL odd_stop2 k=%0d out=%b busy=%b done=%b, required %b 1 0",
                             k, out_po, busy_po, done_po, line_po[k/16]);
                end
            end else if (k == 192) begin
                if (done_po !== 1'b1 || out_po !== 1'b1) begin
                    errors++;
                    $display("FAIL odd_stop2_done out=%b done=%b, required 1 1", out_po, done_po);
                end
            end else begin
                if (busy_po !== 1'b0 || done_po !== 1'b0) begin
                    errors++;
                    $display("FAIL odd_stop2_idle busy=%b done=%b, required 0 0", busy_po, done_po);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] line;
        data_a = 8'h00; start_a = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
        end
        checks++;
        if (out_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre out=%b busy=%b, required 0 1", out_a, busy_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_async out=%b busy=%b done=%b, required 1 0 0", out_a, busy_a, done_a);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold k=%0d out=%b done=%b, required 1 0", k, out_a, done_a);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        line = {1'b1, 8'h5A, 1'b0};
        data_a = 8'h5A; start_a = 1'b1;
        for (int k = 0; k <= 161; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
            checks++;
            if (k < 160) begin
                if (out_a !== line[k/16] || busy_a !== 1'b1 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL after_abort k=%0d out=%b busy=%b done=%b, required %b 1 0",
                             k, out_a, busy_a, done_a, line[k/16]);
                end
            end else if (k == 160) begin
                if (done_a !== 1'b1 || out_a !== 1'b1) begin
                    errors++;
                    $display("FAIL after_abort_done out=%b done=%b, required 1 1", out_a, done_a);
                end
            end else begin
                if (busy_a !== 1'b0 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL after_abort_idle busy=%b done=%b, required 0 0", busy_a, done_a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_midframe_ignored();
        test_back_to_back();
        test_parity_stop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
